// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master (CPU, DMA) arbiter for a shared 16-bit address /
// 8-bit data bus. Each granted access holds the bus for WAIT_CYCLES cycles
// and then pulses the owner's ack.
// DMA can keep ownership across accesses with dma_lock. A pending CPU request
// is forced through once MAX_BURST locked DMA accesses have completed.
// Build option: define ARB_RR_EN for round-robin tie breaking.
// Without it, fixed priority is used and the CPU wins ties.
module bus_arbiter #(
    parameter int WAIT_CYCLES = 2,
    parameter int MAX_BURST   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_ctrl,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    input  logic        dma_req,
    input  logic [15:0] dma_addr,
    input  logic        dma_ctrl,
    input  logic [7:0]  dma_wdata,
    input  logic        dma_lock,
    output logic        dma_ack,
    output logic [7:0]  dma_rdata,
    output logic        bus_valid,
    output logic [15:0] bus_addr,
    output logic        bus_ctrl,
    output logic [7:0]  bus_wdata,
    output logic        bus_oe,
    input  logic [7:0]  bus_rdata,
    output logic [1:0]  grant
);

    // state  | meaning
    // IDLE   | no access in flight; arbitrate when any request is high
    // ACCESS | bus driven with the latched request for WAIT_CYCLES cycles
    // ACK    | one-cycle completion pulse to the owner, bus released
    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_ACCESS = 2'b01;
    localparam logic [1:0] S_ACK    = 2'b10;

    localparam logic [1:0] G_NONE = 2'b00;
    localparam logic [1:0] G_CPU  = 2'b01;
    localparam logic [1:0] G_DMA  = 2'b10;

    // The wait counter is loaded with WAIT_CYCLES-1 and counts down to zero.
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);
    localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

    logic [1:0] state;
    logic [3:0] wait_cnt;
    logic [7:0] burst_cnt;
    logic       lock_pend;   // DMA asked to keep the bus in the last ACK
    logic       force_cpu;
    logic       pick_dma;
    logic       any_req;
    logic       policy_dma;
`ifdef ARB_RR_EN
    logic       rr_dma_next; // 0: CPU wins the next tie, 1: DMA wins it
`endif

    // Arbitration decision. It is only consumed in IDLE.
    always_comb begin
        policy_dma = 1'b0;
`ifdef ARB_RR_EN
        policy_dma = rr_dma_next;
`endif
        any_req   = cpu_req | dma_req;
        force_cpu = cpu_req && (burst_cnt >= BURST_MAX);
        pick_dma  = 1'b0;
        if (dma_req && !force_cpu) begin
            if (!cpu_req || lock_pend || policy_dma) begin
                pick_dma = 1'b1;
            end
        end
    end

    // Sequencer: state, counters, and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            wait_cnt    <= 4'd0;
            burst_cnt   <= 8'd0;
            lock_pend   <= 1'b0;
            grant       <= G_NONE;
            bus_valid   <= 1'b0;
            bus_oe      <= 1'b0;
            bus_addr    <= 16'h0000;
            bus_ctrl    <= 1'b0;
            bus_wdata   <= 8'h00;
            cpu_ack     <= 1'b0;
            dma_ack     <= 1'b0;
            cpu_rdata   <= 8'h00;
            dma_rdata   <= 8'h00;
`ifdef ARB_RR_EN
            rr_dma_next <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    // A lock only carries into the IDLE cycle that
                    // immediately follows the locked access.
                    lock_pend <= 1'b0;
                    if (any_req) begin
                        state     <= S_ACCESS;
                        wait_cnt  <= WAIT_LOAD;
                        bus_valid <= 1'b1;
                        if (pick_dma) begin
                            grant     <= G_DMA;
                            bus_addr  <= dma_addr;
                            bus_ctrl  <= dma_ctrl;
                            bus_wdata <= dma_wdata;
                            bus_oe    <= dma_ctrl;
                        end else begin
                            grant     <= G_CPU;
                            bus_addr  <= cpu_addr;
                            bus_ctrl  <= cpu_ctrl;
                            bus_wdata <= cpu_wdata;
                            bus_oe    <= cpu_ctrl;
                            burst_cnt <= 8'd0;
                        end
`ifdef ARB_RR_EN
                        rr_dma_next <= !pick_dma;
`endif
                    end else begin
                        grant <= G_NONE;
                    end
                end
                S_ACCESS: begin
                    if (wait_cnt == 4'd0) begin
                        state     <= S_ACK;
                        bus_valid <= 1'b0;
                        bus_oe    <= 1'b0;
                        if (grant == G_DMA) begin
                            dma_ack <= 1'b1;
                            if (!bus_ctrl) begin
                                dma_rdata <= bus_rdata;
                            end
                        end else begin
                            cpu_ack <= 1'b1;
                            if (!bus_ctrl) begin
                                cpu_rdata <= bus_rdata;
                            end
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_ACK: begin
                    state   <= S_IDLE;
                    cpu_ack <= 1'b0;
                    dma_ack <= 1'b0;
                    grant   <= G_NONE;
                    if (grant == G_DMA) begin
                        if (dma_lock) begin
                            lock_pend <= 1'b1;
                            // Saturate so that a long uncontested burst
                            // cannot wrap the counter.
                            if (burst_cnt < BURST_MAX) begin
                                burst_cnt <= burst_cnt + 8'd1;
                            end
                        end else begin
                            burst_cnt <= 8'd0;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter (WAIT_CYCLES = 2, MAX_BURST = 4).
module tb_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        cpu_req, dma_req;
    logic [15:0] cpu_addr, dma_addr;
    logic        cpu_ctrl, dma_ctrl;
    logic [7:0]  cpu_wdata, dma_wdata;
    logic        dma_lock;
    logic        cpu_ack, dma_ack;
    logic [7:0]  cpu_rdata, dma_rdata;
    logic        bus_valid;
    logic [15:0] bus_addr;
    logic        bus_ctrl;
    logic [7:0]  bus_wdata;
    logic        bus_oe;
    logic [7:0]  bus_rdata;
    logic [1:0]  grant;

    int vec_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        logic        tmo;
        logic [1:0]  grant;
        logic [15:0] addr;
        logic        ctrl;
        logic [7:0]  wdata;
        logic        oe;
        int          vcyc;
        logic        cack;
        logic        dack;
        logic [7:0]  crd;
        logic [7:0]  drd;
        logic        ack_clr;
        time         t0;
    } obs_t;

    bus_arbiter #(.WAIT_CYCLES(2), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ctrl(cpu_ctrl),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_ctrl(dma_ctrl),
        .dma_wdata(dma_wdata), .dma_lock(dma_lock), .dma_ack(dma_ack),
        .dma_rdata(dma_rdata), .bus_valid(bus_valid), .bus_addr(bus_addr),
        .bus_ctrl(bus_ctrl), .bus_wdata(bus_wdata), .bus_oe(bus_oe),
        .bus_rdata(bus_rdata), .grant(grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait for one access to start, record it, follow it through its ack
    // cycle and one cycle beyond. drop[0]/drop[1] release cpu_req/dma_req
    // once the access is seen on the bus.
    task automatic collect(input logic [1:0] drop, output obs_t o);
        o = '{tmo: 1'b1, grant: 2'b00, addr: 16'h0, ctrl: 1'b0, wdata: 8'h0,
              oe: 1'b0, vcyc: 0, cack: 1'b0, dack: 1'b0, crd: 8'h0,
              drd: 8'h0, ack_clr: 1'b0, t0: 0};
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus_valid) begin
                o.tmo = 1'b0;
                break;
            end
        end
        if (!o.tmo) begin
            o.t0 = $time; o.grant = grant; o.addr = bus_addr;
            o.ctrl = bus_ctrl; o.wdata = bus_wdata; o.oe = bus_oe;
            o.vcyc = 1;
            if (drop[0]) cpu_req = 1'b0;
            if (drop[1]) dma_req = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk); #1;
                if (!bus_valid) break;
                o.vcyc++;
            end
            o.cack = cpu_ack; o.dack = dma_ack;
            o.crd = cpu_rdata; o.drd = dma_rdata;
            @(posedge clk); #1;
            o.ack_clr = !cpu_ack && !dma_ack;
        end
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        vec_cnt++; if (grant !== 2'b00) begin err_cnt++; $display("FAIL reset_grant: got %b want 00", grant); end
        vec_cnt++; if (bus_valid !== 1'b0 || bus_oe !== 1'b0) begin err_cnt++; $display("FAIL reset_valid_oe: got %b%b want 00", bus_valid, bus_oe); end
        vec_cnt++; if (bus_addr !== 16'h0000 || bus_ctrl !== 1'b0 || bus_wdata !== 8'h00) begin err_cnt++; $display("FAIL reset_bus: got %h/%b/%h want 0000/0/00", bus_addr, bus_ctrl, bus_wdata); end
        vec_cnt++; if (cpu_ack !== 1'b0 || dma_ack !== 1'b0) begin err_cnt++; $display("FAIL reset_ack: got %b%b want 00", cpu_ack, dma_ack); end
        vec_cnt++; if (cpu_rdata !== 8'h00 || dma_rdata !== 8'h00) begin err_cnt++; $display("FAIL reset_rdata: got %h/%h want 00/00", cpu_rdata, dma_rdata); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        vec_cnt++; if (bus_valid !== 1'b0 || grant !== 2'b00) begin err_cnt++; $display("FAIL reset_idle: got valid %b grant %b want 0/00", bus_valid, grant); end
    endtask

    task automatic test_cpu_read();
        obs_t o;
        cpu_addr = 16'h0010; cpu_ctrl = 1'b0; bus_rdata = 8'hA5; cpu_req = 1'b1;
        collect(2'b01, o);
        vec_cnt++; if (o.tmo !== 1'b0) begin err_cnt++; $display("FAIL cpu_read_timeout: got %b want 0", o.tmo); end
        vec_cnt++; if (o.grant !== 2'b01) begin err_cnt++; $display("FAIL cpu_read_grant: got %b want 01", o.grant); end
        vec_cnt++; if (o.addr !== 16'h0010 || o.ctrl !== 1'b0 || o.oe !== 1'b0) begin err_cnt++; $display("FAIL cpu_read_bus: got %h/%b/%b want 0010/0/0", o.addr, o.ctrl, o.oe); end
        vec_cnt++; if (o.vcyc !== 2) begin err_cnt++; $display("FAIL cpu_read_wait: got %0d want 2", o.vcyc); end
        vec_cnt++; if (o.cack !== 1'b1 || o.dack !== 1'b0) begin err_cnt++; $display("FAIL cpu_read_ack: got %b%b want 10", o.cack, o.dack); end
        vec_cnt++; if (o.crd !== 8'hA5) begin err_cnt++; $display("FAIL cpu_read_rdata: got %h want a5", o.crd); end
        vec_cnt++; if (o.ack_clr !== 1'b1) begin err_cnt++; $display("FAIL cpu_read_ack_pulse: got %b want 1", o.ack_clr); end
        vec_cnt++; if (grant !== 2'b00) begin err_cnt++; $display("FAIL cpu_read_release: got %b want 00", grant); end
    endtask

    task automatic test_dma_write();
        obs_t o;
        dma_addr = 16'hFF00; dma_ctrl = 1'b1; dma_wdata = 8'h3C; dma_lock = 1'b0;
        bus_rdata = 8'hEE; dma_req = 1'b1;
        collect(2'b10, o);
        vec_cnt++; if (o.tmo !== 1'b0) begin err_cnt++; $display("FAIL dma_write_timeout: got %b want 0", o.tmo); end
        vec_cnt++; if (o.grant !== 2'b10) begin err_cnt++; $display("FAIL dma_write_grant: got %b want 10", o.grant); end
        vec_cnt++; if (o.addr !== 16'hFF00 || o.ctrl !== 1'b1 || o.wdata !== 8'h3C || o.oe !== 1'b1) begin err_cnt++; $display("FAIL dma_write_bus: got %h/%b/%h/%b want ff00/1/3c/1", o.addr, o.ctrl, o.wdata, o.oe); end
        vec_cnt++; if (o.vcyc !== 2) begin err_cnt++; $display("FAIL dma_write_wait: got %0d want 2", o.vcyc); end
        vec_cnt++; if (o.dack !== 1'b1 || o.cack !== 1'b0) begin err_cnt++; $display("FAIL dma_write_ack: got c%b d%b want c0 d1", o.cack, o.dack); end
        vec_cnt++; if (o.drd !== 8'h00 || o.crd !== 8'hA5) begin err_cnt++; $display("FAIL dma_write_rdata_hold: got d%h c%h want d00 ca5", o.drd, o.crd); end
    endtask

    task automatic test_tie();
        obs_t o;
        logic [1:0] exp_g [4];
        time t_first;
`ifdef ARB_RR_EN
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        apply_reset();
        t_first = 0;
        cpu_addr = 16'h0100; cpu_ctrl = 1'b0; dma_addr = 16'h0200; dma_ctrl = 1'b0;
        dma_lock = 1'b0; bus_rdata = 8'h11; cpu_req = 1'b1; dma_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            collect(2'b00, o);
            vec_cnt++; if (o.grant !== exp_g[k]) begin err_cnt++; $display("FAIL tie_grant[%0d]: got %b want %b", k, o.grant, exp_g[k]); end
            if (k == 0) t_first = o.t0;
            if (k == 1) begin
                vec_cnt++; if (o.t0 - t_first !== 40) begin err_cnt++; $display("FAIL tie_spacing: got %0t want 40", o.t0 - t_first); end
            end
        end
        cpu_req = 1'b0; dma_req = 1'b0;
    endtask

    task automatic test_burst();
        obs_t o;
        logic [1:0] exp_g [5];
        exp_g = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
        apply_reset();
        dma_addr = 16'h2000; dma_ctrl = 1'b0; dma_lock = 1'b1;
        cpu_addr = 16'h3000; cpu_ctrl = 1'b0; bus_rdata = 8'h5A; dma_req = 1'b1;
        collect(2'b00, o);
        vec_cnt++; if (o.grant !== 2'b10) begin err_cnt++; $display("FAIL burst_first: got %b want 10", o.grant); end
        vec_cnt++; if (o.drd !== 8'h5A) begin err_cnt++; $display("FAIL burst_dma_rdata: got %h want 5a", o.drd); end
        cpu_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            collect((k == 3) ? 2'b01 : 2'b00, o);
            vec_cnt++; if (o.grant !== exp_g[k]) begin err_cnt++; $display("FAIL burst_grant[%0d]: got %b want %b", k + 1, o.grant, exp_g[k]); end
            if (k == 3) begin
                vec_cnt++; if (o.cack !== 1'b1 || o.crd !== 8'h5A) begin err_cnt++; $display("FAIL burst_cpu_access: got ack %b rdata %h want 1/5a", o.cack, o.crd); end
            end
        end
        dma_req = 1'b0; dma_lock = 1'b0; cpu_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        obs_t o;
        int acks;
        int valids;
        cpu_addr = 16'h1234; cpu_ctrl = 1'b1; cpu_wdata = 8'h77; cpu_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        vec_cnt++; if (bus_valid !== 1'b1) begin err_cnt++; $display("FAIL rst_mid_access: got valid %b want 1", bus_valid); end
        cpu_req = 1'b0;
        rst_n = 1'b0;
        #1;
        vec_cnt++; if (bus_valid !== 1'b0 || bus_oe !== 1'b0 || grant !== 2'b00) begin err_cnt++; $display("FAIL rst_mid_ctrl: got %b/%b/%b want 0/0/00", bus_valid, bus_oe, grant); end
        vec_cnt++; if (bus_addr !== 16'h0000 || bus_ctrl !== 1'b0 || bus_wdata !== 8'h00) begin err_cnt++; $display("FAIL rst_mid_bus: got %h/%b/%h want 0000/0/00", bus_addr, bus_ctrl, bus_wdata); end
        vec_cnt++; if (cpu_rdata !== 8'h00 || dma_rdata !== 8'h00 || cpu_ack !== 1'b0 || dma_ack !== 1'b0) begin err_cnt++; $display("FAIL rst_mid_resp: got %h/%h/%b/%b want 00/00/0/0", cpu_rdata, dma_rdata, cpu_ack, dma_ack); end
        #2;
        rst_n = 1'b1;
        acks = 0; valids = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (cpu_ack || dma_ack) acks++;
            if (bus_valid) valids++;
        end
        vec_cnt++; if (acks !== 0 || valids !== 0) begin err_cnt++; $display("FAIL rst_mid_no_ack: got acks %0d valid %0d want 0/0", acks, valids); end
        cpu_addr = 16'h0042; cpu_ctrl = 1'b0; bus_rdata = 8'hC3; cpu_req = 1'b1;
        collect(2'b01, o);
        vec_cnt++; if (o.tmo !== 1'b0 || o.grant !== 2'b01 || o.addr !== 16'h0042) begin err_cnt++; $display("FAIL rst_mid_resume: got tmo %b grant %b addr %h want 0/01/0042", o.tmo, o.grant, o.addr); end
        vec_cnt++; if (o.cack !== 1'b1 || o.crd !== 8'hC3 || o.vcyc !== 2) begin err_cnt++; $display("FAIL rst_mid_resume_ack: got %b/%h/%0d want 1/c3/2", o.cack, o.crd, o.vcyc); end
    endtask

    initial begin
        rst_n = 1'b0;
        cpu_req = 1'b0; dma_req = 1'b0; dma_lock = 1'b0;
        cpu_addr = 16'h0; dma_addr = 16'h0; cpu_ctrl = 1'b0; dma_ctrl = 1'b0;
        cpu_wdata = 8'h0; dma_wdata = 8'h0; bus_rdata = 8'h0;
        test_reset();
        test_cpu_read();
        test_dma_write();
        test_tie();
        test_burst();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
